sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, SRAM word-address width.
REQ-002 SHALL have parameter WORD_WIDTH, default 32, data width.
REQ-003 SHALL have parameter BYTES, default WORD_WIDTH/8, byte-enable width.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports p0_req in 1, p0_addr in 32, p0_gnt out 1, p0_rvalid out 1, p0_rdata out WORD_WIDTH, p0_err out 1: instruction port, read-only, byte address.
REQ-007 SHALL have ports p1_req in 1, p1_we in 1, p1_be in BYTES, p1_addr in 32, p1_wdata in WORD_WIDTH, p1_gnt out 1, p1_rvalid out 1, p1_rdata out WORD_WIDTH, p1_err out 1: data port, byte address.
REQ-008 SHALL have ports mem_addr out ADDR_WIDTH, mem_be out BYTES, mem_we out 1, mem_wdata out WORD_WIDTH, mem_rdata in WORD_WIDTH: single-port SRAM with 1-cycle registered read.

Function
REQ-009 SHALL grant at most one port per cycle; gnt combinational from req and the priority pointer.
REQ-010 SHALL grant the only requesting port when one port requests.
REQ-011 SHALL, when both request, grant the port named by the 1-bit priority pointer prio (0 -> p0, 1 -> p1).
REQ-012 SHALL, on a contended grant, set prio to the non-granted port next cycle; uncontended grants leave prio unchanged.
REQ-013 SHALL treat a request as accepted in the cycle req and gnt are both high; the requester holds req/addr/data stable until gnt.
REQ-014 SHALL drive mem_addr = granted addr[ADDR_WIDTH+1:2]; addr[1:0] ignored.
REQ-015 SHALL drive mem_we = p1_we, mem_be = p1_be, mem_wdata = p1_wdata on p1 grant; mem_we = 0 on p0 grant; mem_be all-ones on p0 grant.
REQ-016 SHALL drive mem_addr = 0, mem_we = 0, mem_be = 0, mem_wdata = 0 when no grant.
REQ-017 SHALL flag an access out-of-range when granted addr[31:ADDR_WIDTH+2] is nonzero; the access is still accepted but mem_we is forced 0.
REQ-018 SHALL register the granted port id, a valid bit and the out-of-range bit at the accepting edge.
REQ-019 SHALL, exactly one cycle after acceptance, pulse rvalid for one cycle on the accepting port only, for both reads and writes.
REQ-020 SHALL present rdata = mem_rdata with rvalid for an in-range read; rdata = 0 for writes and for out-of-range accesses.
REQ-021 SHALL assert err together with rvalid iff the access was out-of-range; err otherwise 0.
REQ-022 SHALL support back-to-back acceptance every cycle, including alternating ports, with no bubble; throughput one access per cycle.
REQ-023 SHALL drive rdata and err to 0 whenever the corresponding rvalid is 0.
REQ-024 SHALL make a write followed next cycle by a read of the same word return the new data, as given by SRAM write-then-read ordering.

Reset
REQ-025 SHALL, while rst_n = 0, clear prio to 0 and clear the registered valid, port id and err bits.
REQ-026 SHALL hold p0_rvalid, p1_rvalid, p0_err, p1_err at 0 and rdata at 0 during reset; gnt and mem_* remain combinational from req.
REQ-027 SHALL discard any access accepted in the cycle before reset assertion; no rvalid follows after reset release.
REQ-028 SHALL accept requests in the first rising edge with rst_n = 1.

Verification
REQ-029 SHALL pass: p0 read addr 0x10 with SRAM word 4 = 0xDEADBEEF -> p0_gnt same cycle, mem_addr=4, next cycle p0_rvalid=1, p0_rdata=0xDEADBEEF, p1_rvalid=0.
REQ-030 SHALL pass: p0 and p1 both request continuously for 4 cycles after reset -> grants p0,p1,p0,p1, each rvalid one cycle after its grant.
REQ-031 SHALL pass: p1 write addr 0x20 be=4'b0011 wdata=0x12345678 over word 0xFFFFFFFF, then p1 read 0x20 -> p1_rdata=0xFFFF5678, write rvalid has rdata=0.
REQ-032 SHALL pass: p1 write addr 0x0000_4000 (ADDR_WIDTH=12) -> mem_we=0, next cycle p1_rvalid=1, p1_err=1, p1_rdata=0.
REQ-033 SHALL pass: p0 read accepted, rst_n pulsed low before next edge -> no p0_rvalid, prio=0, next contended request granted to p0.
REQ-034 SHALL pass: p1 alone requesting 3 cycles, then contention with prio=0 -> p1 granted 3 times, then p0 wins contention.

Source files
------------

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//   Two-port arbiter in front of a single-port SRAM with a 1-cycle registered
//   read. Port 0 is a read-only instruction port; port 1 is a read/write data
//   port. Grants are combinational from the requests and a 1-bit priority
//   pointer that alternates only under contention. Every accepted access is
//   answered exactly one cycle later with an rvalid pulse on the accepting
//   port, carrying read data (in-range reads) or an error flag (out-of-range).
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   p0_req/addr                 instruction port request (byte address)
//   p0_gnt/rvalid/rdata/err     instruction port grant and response
//   p1_req/we/be/addr/wdata     data port request (byte address)
//   p1_gnt/rvalid/rdata/err     data port grant and response
//   mem_addr/be/we/wdata        SRAM command (word address)
//   mem_rdata                   SRAM read data, valid the cycle after a read
// -----------------------------------------------------------------------------
module sram_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int WORD_WIDTH = 32,
    parameter int BYTES      = WORD_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  p0_req,
    input  logic [31:0]           p0_addr,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic [WORD_WIDTH-1:0] p0_rdata,
    output logic                  p0_err,

    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [BYTES-1:0]      p1_be,
    input  logic [31:0]           p1_addr,
    input  logic [WORD_WIDTH-1:0] p1_wdata,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [WORD_WIDTH-1:0] p1_rdata,
    output logic                  p1_err,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [BYTES-1:0]      mem_be,
    output logic                  mem_we,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    input  logic [WORD_WIDTH-1:0] mem_rdata
);

    // Priority pointer: 0 favours p0, 1 favours p1 when both request.
    logic prio_q, prio_d;

    // Response pipeline: one entry describing the access accepted last edge.
    logic vld_q,  vld_d;    // an access was accepted
    logic port_q, port_d;   // 0 = p0, 1 = p1
    logic oor_q,  oor_d;    // access was out of range
    logic rd_q,   rd_d;     // access was a read (return SRAM data)

    logic        gnt0, gnt1;
    logic [31:0] sel_addr;
    logic        oor;
    logic [WORD_WIDTH-1:0] resp_data;

    // -------------------------------------------------------------------------
    // Arbitration and SRAM command
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch so that no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        prio_d    = prio_q;
        mem_addr  = '0;
        mem_be    = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;

        if (p0_req && p1_req) begin
            gnt1   = prio_q;
            gnt0   = ~prio_q;
            // The winner was the port named by prio; hand priority to the loser.
            prio_d = ~prio_q;
        end else begin
            gnt0 = p0_req;
            gnt1 = p1_req;
        end

        sel_addr = gnt1 ? p1_addr : p0_addr;
        // Any address bit above the SRAM's byte range makes the access illegal.
        oor      = (sel_addr >> (ADDR_WIDTH + 2)) != 32'd0;

        if (gnt0) begin
            mem_addr = sel_addr[ADDR_WIDTH+1:2];
            mem_be   = '1;
        end else if (gnt1) begin
            mem_addr  = sel_addr[ADDR_WIDTH+1:2];
            mem_be    = p1_be;
            mem_we    = p1_we & ~oor;   // out-of-range writes are accepted but dropped
            mem_wdata = p1_wdata;
        end

        vld_d  = gnt0 | gnt1;
        port_d = gnt1;
        oor_d  = oor;
        rd_d   = gnt0 | (gnt1 & ~p1_we);
    end

    assign p0_gnt = gnt0;
    assign p1_gnt = gnt1;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
            vld_q  <= 1'b0;
            port_q <= 1'b0;
            oor_q  <= 1'b0;
            rd_q   <= 1'b0;
        end else begin
            prio_q <= prio_d;
            vld_q  <= vld_d;
            port_q <= port_d;
            oor_q  <= oor_d;
            rd_q   <= rd_d;
        end
    end

    // -------------------------------------------------------------------------
    // Response: SRAM data only for in-range reads, zero otherwise. Because
    // vld_q is cleared asynchronously, all response outputs are 0 in reset and
    // any access accepted just before reset never produces an rvalid.
    // -------------------------------------------------------------------------
    assign resp_data = (vld_q && rd_q && !oor_q) ? mem_rdata : '0;

    assign p0_rvalid = vld_q & ~port_q;
    assign p1_rvalid = vld_q &  port_q;
    assign p0_rdata  = p0_rvalid ? resp_data : '0;
    assign p1_rdata  = p1_rvalid ? resp_data : '0;
    assign p0_err    = p0_rvalid & oor_q;
    assign p1_err    = p1_rvalid & oor_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
//   Self-checking bench for sram_arbiter. An SRAM behavioural model sits on the
//   mem_* port; a transaction-level reference model (priority bit, shadow
//   memory, one pending response) predicts grants, SRAM commands and responses.
//   Directed scenarios are followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;

    localparam int AW    = 12;
    localparam int WW    = 32;
    localparam int BY    = WW / 8;
    localparam int WORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          p0_req;
    logic [31:0]   p0_addr;
    logic          p0_gnt, p0_rvalid, p0_err;
    logic [WW-1:0] p0_rdata;
    logic          p1_req, p1_we;
    logic [BY-1:0] p1_be;
    logic [31:0]   p1_addr;
    logic [WW-1:0] p1_wdata;
    logic          p1_gnt, p1_rvalid, p1_err;
    logic [WW-1:0] p1_rdata;
    logic [AW-1:0] mem_addr;
    logic [BY-1:0] mem_be;
    logic          mem_we;
    logic [WW-1:0] mem_wdata;
    logic [WW-1:0] mem_rdata;

    sram_arbiter #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .BYTES(BY)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_gnt(p0_gnt),
        .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_be(p1_be), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
        .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // SRAM environment: byte-masked write, registered read.
    logic [WW-1:0] sram [0:WORDS-1];
    always @(posedge clk) begin
        if (mem_we)
            for (int b = 0; b < BY; b++)
                if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        mem_rdata <= sram[mem_addr];
    end

    // Reference model state.
    logic [WW-1:0] shadow [0:WORDS-1];
    bit            m_prio;
    bit            m_g0, m_g1;
    bit            pv, pport, perr;
    logic [WW-1:0] pdata;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One bus cycle: drive at the falling edge, check outputs 1 ns later,
    // then advance the model to the state after the coming rising edge.
    task automatic step(input bit r0, input logic [31:0] a0,
                        input bit r1, input bit we, input logic [BY-1:0] be,
                        input logic [31:0] a1, input logic [WW-1:0] wd);
        logic [31:0] ga;
        bit          oor;
        int          w;
        @(negedge clk);
        p0_req = r0; p0_addr = a0;
        p1_req = r1; p1_we = we; p1_be = be; p1_addr = a1; p1_wdata = wd;
        #1;
        if (r0 && r1) begin
            m_g1   = m_prio;
            m_g0   = !m_prio;
            m_prio = !m_prio;
        end else begin
            m_g0 = r0;
            m_g1 = r1;
        end
        check("p0_gnt", p0_gnt, m_g0);
        check("p1_gnt", p1_gnt, m_g1);

        ga  = m_g1 ? a1 : a0;
        oor = ga >= (32'd4 << AW);
        w   = int'((ga / 4) % WORDS);
        if (m_g0) begin
            check("mem_addr_p0", mem_addr, w);
            check("mem_we_p0",   mem_we, 0);
            check("mem_be_p0",   mem_be, {BY{1'b1}});
        end else if (m_g1) begin
            check("mem_addr_p1",  mem_addr, w);
            check("mem_we_p1",    mem_we, we && !oor);
            check("mem_be_p1",    mem_be, be);
            check("mem_wdata_p1", mem_wdata, wd);
        end else begin
            check("mem_addr_idle",  mem_addr, 0);
            check("mem_we_idle",    mem_we, 0);
            check("mem_be_idle",    mem_be, 0);
            check("mem_wdata_idle", mem_wdata, 0);
        end

        check("p0_rvalid", p0_rvalid, pv && !pport);
        check("p0_rdata",  p0_rdata,  (pv && !pport) ? pdata : 0);
        check("p0_err",    p0_err,    pv && !pport && perr);
        check("p1_rvalid", p1_rvalid, pv && pport);
        check("p1_rdata",  p1_rdata,  (pv && pport) ? pdata : 0);
        check("p1_err",    p1_err,    pv && pport && perr);

        pv    = m_g0 || m_g1;
        pport = m_g1;
        perr  = oor;
        pdata = (pv && !oor && !(m_g1 && we)) ? shadow[w] : 0;
        if (m_g1 && we && !oor)
            for (int b = 0; b < BY; b++)
                if (be[b]) shadow[w][8*b +: 8] = wd[8*b +: 8];
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_p0_rvalid", p0_rvalid, 0);
        check("rst_p1_rvalid", p1_rvalid, 0);
        check("rst_p0_rdata",  p0_rdata, 0);
        check("rst_p0_err",    p0_err, 0);
        pv     = 0;
        m_prio = 0;
        #1 rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 9) == 0)
            return $urandom | (32'd1 << (AW + 2 + $urandom_range(0, 29 - AW)));
        return $urandom_range(0, 15) * 4 + $urandom_range(0, 3);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit            h0, h1, rwe;
        logic [31:0]   ra0, ra1;
        logic [WW-1:0] rwd;
        logic [BY-1:0] rbe;

        rst_n = 1'b0;
        p0_req = 0; p0_addr = 0;
        p1_req = 0; p1_we = 0; p1_be = 0; p1_addr = 0; p1_wdata = 0;
        for (int i = 0; i < WORDS; i++) begin
            sram[i]   = $urandom;
            shadow[i] = sram[i];
        end
        sram[4] = 32'hDEADBEEF; shadow[4] = 32'hDEADBEEF;
        sram[8] = 32'hFFFFFFFF; shadow[8] = 32'hFFFFFFFF;
        m_prio = 0; pv = 0; pport = 0; perr = 0; pdata = 0;

        // Grant stays combinational in reset; responses stay quiet.
        #7 p0_req = 1; p0_addr = 32'h10;
        #1;
        check("rst_gnt_comb",  p0_gnt, 1);
        check("rst_addr_comb", mem_addr, 4);
        check("rst_rvalid",    p0_rvalid, 0);
        p0_req = 0;

        // Release at t=22; the request driven at t=20 is accepted at t=25,
        // the first rising edge with rst_n high.
        #9;
        fork
            #5 rst_n = 1'b1;
        join_none

        // p0 read of word 4.
        step(1, 32'h10, 0, 0, 0, 0, 0);
        check("r29_mem_addr", mem_addr, 4);
        idle();
        check("r29_rvalid", p0_rvalid, 1);
        check("r29_rdata",  p0_rdata, 32'hDEADBEEF);
        check("r29_p1rv",   p1_rvalid, 0);

        // p1 alone for three cycles, then contention with prio=0.
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0, 0, 32'h4 * i, 0);
            check("r34_p1_gnt", p1_gnt, 1);
        end
        step(1, 32'h8, 1, 0, 0, 32'hC, 0);
        check("r34_p0_wins", p0_gnt, 1);

        // p0 read accepted, then a reset pulse before the next edge.
        step(1, 32'h10, 0, 0, 0, 0, 0);
        reset_pulse();
        for (int i = 0; i < 4; i++) begin
            step(1, 32'h4 * i, 1, 0, 0, 32'h40 + 32'h4 * i, 0);
            if (i == 0) check("r33_no_rvalid", p0_rvalid, 0);
            check("r30_alt_p0", p0_gnt, (i % 2) == 0);
            check("r30_alt_p1", p1_gnt, (i % 2) == 1);
        end

        // Partial write then read of the same word.
        step(0, 0, 1, 1, 4'b0011, 32'h20, 32'h12345678);
        step(0, 0, 1, 0, 0, 32'h20, 0);
        check("r31_wr_rvalid", p1_rvalid, 1);
        check("r31_wr_rdata",  p1_rdata, 0);
        idle();
        check("r31_rd_rdata",  p1_rdata, 32'hFFFF5678);

        // Out-of-range write.
        step(0, 0, 1, 1, 4'hF, 32'h0000_4000, 32'hCAFEF00D);
        check("r32_mem_we", mem_we, 0);
        idle();
        check("r32_rvalid", p1_rvalid, 1);
        check("r32_err",    p1_err, 1);
        check("r32_rdata",  p1_rdata, 0);

        // Randomized traffic; each requester holds its request until granted.
        h0 = 0; h1 = 0; ra0 = 0; ra1 = 0; rwe = 0; rbe = 0; rwd = 0;
        for (int c = 0; c < 800; c++) begin
            if (!h0 && $urandom_range(0, 3) != 0) begin
                h0 = 1; ra0 = rand_addr();
            end
            if (!h1 && $urandom_range(0, 3) != 0) begin
                h1 = 1; rwe = 1'($urandom_range(0, 1)); rbe = BY'($urandom);
                ra1 = rand_addr(); rwd = $urandom;
            end
            step(h0, ra0, h1, rwe, rbe, ra1, rwd);
            if (m_g0) h0 = 0;
            if (m_g1) h1 = 0;
        end
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
